// File: rtl/burst_pkg.sv
// Shared constants, FSM state type and address helper for the burst memory responder.
package burst_pkg;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEATS  = 4;

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} resp_state_t;

    // Line index from a byte address; bits above the array size alias.
    function automatic int unsigned line_index(input logic [31:0] addr, input int unsigned lines);
        return 32'(addr >> 5) & (lines - 1);
    endfunction

endpackage

// File: rtl/burst_line_ram.sv
// Line storage: LINES x 256-bit single-port array, asynchronous read, registered full-line write.
module burst_line_ram
    import burst_pkg::*;
#(
    parameter int unsigned LINES = 16,
    localparam int unsigned IdxW = $clog2(LINES)
) (
    input  logic              clk,
    input  logic [IdxW-1:0]   addr_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4-beat 64-bit burst interface with programmable latency.
module burst_mem_responder
    import burst_pkg::*;
#(
    parameter int unsigned LINES   = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              err_o
);

    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_t       state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic [1:0]        beat_q, beat_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic              resp_q, resp_d;
    logic [BEAT_W-1:0] burst_q, burst_d;
    logic              err_q, err_d;

    logic              req_ok;
    logic              req_held;
    logic [1:0]        beat_nx;
    logic [LINE_W-1:0] buf_wr;
    logic [IdxW-1:0]   ram_addr;
    logic              ram_we;
    logic [LINE_W-1:0] ram_rdata;

    // The single port serves the IDLE read snapshot and the beat-3 commit.
    assign ram_addr = (state_q == StBurst) ? idx_q : IdxW'(line_index(address_i, LINES));

    burst_line_ram #(
        .LINES (LINES)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (buf_wr),
        .rdata_o (ram_rdata)
    );

    // A transaction stays alive only while its own request alone is asserted.
    assign req_ok   = wr_q ? (write_i & ~read_i) : (read_i & ~write_i);
    assign req_held = wr_q ? write_i : read_i;
    assign beat_nx  = beat_q + 2'd1;

    always_comb begin
        buf_wr = buf_q;
        buf_wr[BEAT_W*beat_q +: BEAT_W] = burst_i;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        err_d   = err_q;
        resp_d  = 1'b0;
        burst_d = '0;
        ram_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (read_i ^ write_i) begin
                    idx_d   = IdxW'(line_index(address_i, LINES));
                    wr_d    = write_i;
                    lat_d   = LatW'(LATENCY - 1);
                    state_d = StWait;
                    if (read_i) begin
                        buf_d = ram_rdata;
                    end
                end else if (read_i && write_i) begin
                    err_d = 1'b1;
                end
            end
            StWait: begin
                if (!req_ok) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (lat_q == '0) begin
                    state_d = StBurst;
                    beat_d  = 2'd0;
                    resp_d  = 1'b1;
                    burst_d = wr_q ? '0 : buf_q[BEAT_W-1:0];
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StBurst: begin
                if (!req_ok) begin
                    state_d = StIdle;
                    beat_d  = 2'd0;
                    err_d   = 1'b1;
                end else begin
                    if (wr_q) begin
                        buf_d = buf_wr;
                    end
                    if (beat_q == 2'(BEATS - 1)) begin
                        ram_we  = wr_q;
                        beat_d  = 2'd0;
                        state_d = StDone;
                    end else begin
                        beat_d  = beat_nx;
                        resp_d  = 1'b1;
                        burst_d = wr_q ? '0 : buf_q[BEAT_W*beat_nx +: BEAT_W];
                    end
                end
            end
            StDone: begin
                if (!req_held) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            lat_q   <= '0;
            beat_q  <= '0;
            buf_q   <= '0;
            resp_q  <= 1'b0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            resp_q  <= resp_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    assign resp_o  = resp_q;
    assign burst_o = burst_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed scoreboard bench for burst_mem_responder at LATENCY 4, 1 and 7.
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [63:0] bin;
    logic [2:0]  rd, wr;
    logic [63:0] bo [3];
    logic [2:0]  rsp, er;

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    logic [255:0] exp_q [$];
    logic [255:0] model [3][16];

    always #5 clk = ~clk;

    burst_mem_responder #(.LINES(16), .LATENCY(4)) dut (
        .clk(clk), .rst(rst), .address_i(addr), .read_i(rd[0]), .write_i(wr[0]),
        .burst_i(bin), .burst_o(bo[0]), .resp_o(rsp[0]), .err_o(er[0])
    );
    burst_mem_responder #(.LINES(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .address_i(addr), .read_i(rd[1]), .write_i(wr[1]),
        .burst_i(bin), .burst_o(bo[1]), .resp_o(rsp[1]), .err_o(er[1])
    );
    burst_mem_responder #(.LINES(16), .LATENCY(7)) dut_l7 (
        .clk(clk), .rst(rst), .address_i(addr), .read_i(rd[2]), .write_i(wr[2]),
        .burst_i(bin), .burst_o(bo[2]), .resp_o(rsp[2]), .err_o(er[2])
    );

    function automatic int lat_of(input int s);
        case (s)
            1:       return 1;
            2:       return 7;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: full transaction, 1: drop request during beat 2, 2: reset during beat 2
    task automatic run(input bit w, input logic [31:0] a, input logic [255:0] line, input int mode);
        int beats = 0;
        int lat   = lat_of(sel);
        int idx   = int'(a[8:5]);
        bit fin   = 1'b0;
        logic [255:0] ev;
        if (!w) begin
            for (int b = 0; b < 4; b++) exp_q.push_back({192'b0, model[sel][idx][64*b +: 64]});
        end
        addr = a;
        bin  = '0;
        if (w) wr[sel] = 1'b1; else rd[sel] = 1'b1;
        for (int m = 1; m <= 40 && !fin; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp[sel] && beats == 4) begin
                check("extra_beat", {255'b0, rsp[sel]}, 256'd0);
                fin = 1'b1;
            end else if (rsp[sel]) begin
                check("resp_cycle", m, lat + beats + 1);
                if (!w) begin
                    if (exp_q.size() == 0) ev = 'x; else ev = exp_q.pop_front();
                    check("rdata", {192'b0, bo[sel]}, ev);
                end
                if (mode != 0 && beats == 2) begin
                    rd[sel] = 1'b0;
                    wr[sel] = 1'b0;
                    if (mode == 2) rst = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    check("abort_resp", {255'b0, rsp[sel]}, 256'd0);
                    if (mode == 1) begin
                        check("abort_err", {255'b0, er[sel]}, 256'd1);
                    end else begin
                        check("rst_burst_o", {192'b0, bo[sel]}, 256'd0);
                        check("rst_err", {255'b0, er[sel]}, 256'd0);
                        rst = 1'b1;
                        exp_q.delete();
                    end
                    fin = 1'b1;
                end else begin
                    if (w) bin = line[64*beats +: 64];
                    beats++;
                end
            end else if (beats == 4) begin
                rd[sel] = 1'b0;
                wr[sel] = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                if (w) model[sel][idx] = line;
                fin = 1'b1;
            end
        end
        if (!fin) check("timeout_beats", beats, 4);
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
    endtask

    initial begin
        logic [255:0] la, lb, lc, ld;
        la = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lb = {64'hBBBB_0003_0000_0000, 64'hBBBB_0002_0000_0000,
              64'hBBBB_0001_0000_0000, 64'hBBBB_0000_0000_0000};
        lc = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
              64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
        ld = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
              64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        rst  = 1'b0;
        addr = '0;
        bin  = '0;
        rd   = '0;
        wr   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_resp", {255'b0, rsp[s]}, 256'd0);
            check("reset_burst_o", {192'b0, bo[s]}, 256'd0);
            check("reset_err", {255'b0, er[s]}, 256'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        sel = 0;
        run(1'b1, 32'h0000_0040, la, 0);
        run(1'b0, 32'h0000_0040, '0, 0);
        check("no_err_after_rw", {255'b0, er[0]}, 256'd0);

        run(1'b1, 32'h0000_0040, lb, 1);
        @(negedge clk);
        run(1'b0, 32'h0000_0040, '0, 0);
        check("err_sticky", {255'b0, er[0]}, 256'd1);

        run(1'b0, 32'h0000_0040, '0, 2);
        @(negedge clk);
        run(1'b0, 32'h0000_0040, '0, 0);

        run(1'b1, 32'h0000_0200, lc, 0);
        run(1'b0, 32'h0000_0000, '0, 0);

        sel = 1;
        run(1'b1, 32'h0000_0060, ld, 0);
        run(1'b0, 32'h0000_0060, '0, 0);
        sel = 2;
        run(1'b1, 32'h0000_0060, ld, 0);
        run(1'b0, 32'h0000_0060, '0, 0);

        sel   = 0;
        rst   = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        addr  = 32'h0000_0040;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("illegal_no_resp", {255'b0, rsp[0]}, 256'd0);
        end
        check("illegal_err", {255'b0, er[0]}, 256'd1);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
